cs_result_buffer: RTL and testbench

Downstream stage of the CS computational system: it consumes the 10-bit approximated-average stream Y, discards the warm-up results produced while the 9-sample window is still filling, and queues the valid results in a small FIFO. A valid/ready handshake drains the FIFO toward the result checker or host interface. It also keeps a sequence index and overflow statistics, so lost results are detectable.

---
 rtl/cs_pkg.sv | 40 ++++
 rtl/cs_result_buffer_if.sv | 38 +++
 rtl/cs_sync_fifo.sv | 96 +++++++++
 rtl/cs_result_buffer.sv | 131 +++++++++++++
 tb/tb_cs_result_buffer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cs_pkg.sv
// ---------------------------------------------------------------------------
// cs_pkg
// Shared definitions for the CS result buffer slice.
//   Y_W     : width of one CS result
//   DEPTH   : result FIFO entries (power of two, >= 2)
//   WARMUP  : valid samples thrown away after reset while the window fills
//   IDX_W   : width of the per-result sequence index
//   state_t : buffer FSM states (WARM, RUN)
//   entry_t : one queued result {idx, data}
//   sat_inc : saturating increment used by the drop counter
// ---------------------------------------------------------------------------
package cs_pkg;

    localparam int Y_W    = 10;
    localparam int DEPTH  = 8;
    localparam int WARMUP = 8;
    localparam int IDX_W  = 8;

    typedef enum logic [0:0] {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [Y_W-1:0]   data;
    } entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        if (v == {IDX_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/cs_result_buffer_if.sv
// ---------------------------------------------------------------------------
// cs_result_buffer_if
// Bundles the CS result input stream, the drained result stream and the
// loss statistics of the result buffer.
//   y / y_valid                  : incoming CS results
//   dout / dout_idx / dout_valid : head of the result queue
//   dout_ready                   : consumer accepts dout
//   overflow / drop_cnt / level  : loss statistics and queue occupancy
// Modports: slave = the buffer, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface cs_result_buffer_if
    import cs_pkg::*;
#(
    parameter int Y_W_P   = Y_W,
    parameter int DEPTH_P = DEPTH
) ();

    logic [Y_W_P-1:0]          y;
    logic                      y_valid;
    logic [Y_W_P-1:0]          dout;
    logic [IDX_W-1:0]          dout_idx;
    logic                      dout_valid;
    logic                      dout_ready;
    logic                      overflow;
    logic [7:0]                drop_cnt;
    logic [$clog2(DEPTH_P):0]  level;

    modport slave (
        input  y, y_valid, dout_ready,
        output dout, dout_idx, dout_valid, overflow, drop_cnt, level
    );

    modport master (
        output y, y_valid, dout_ready,
        input  dout, dout_idx, dout_valid, overflow, drop_cnt, level
    );

endinterface

// File: rtl/cs_sync_fifo.sv
// ---------------------------------------------------------------------------
// cs_sync_fifo
// Single-clock FIFO with a registered head. The head register always holds
// the entry that will be at the front after the current edge, so a push into
// an empty FIFO is visible one cycle later and a pop exposes the next entry
// on the same edge.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored when full without a pop)
//   pop        : read request (ignored when empty)
//   head       : registered front entry
//   full/empty : occupancy flags (empty is registered)
//   level      : occupancy, wr_ptr - rd_ptr
// ---------------------------------------------------------------------------
module cs_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Pointers carry one extra wrap bit so wr - rd distinguishes full from empty.
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [LW-1:0]    level_s;
    logic [LW-1:0]    level_next_s;
    logic [LW-1:0]    level_after_pop_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;

    assign level_s = wr_ptr_q - rd_ptr_q;
    assign full_s  = (level_s == LW'(DEPTH));
    assign pop_s   = pop & valid_q;
    assign push_s  = push & (~full_s | pop_s);

    // Next pointers, occupancy and head-register contents.
    always_comb begin
        wr_ptr_d          = wr_ptr_q + {{AW{1'b0}}, push_s};
        rd_ptr_d          = rd_ptr_q + {{AW{1'b0}}, pop_s};
        level_next_s      = wr_ptr_d - rd_ptr_d;
        level_after_pop_s = level_s - {{AW{1'b0}}, pop_s};
        valid_d           = (level_next_s != {LW{1'b0}});
        head_d            = head_q;
        if (level_next_s == {LW{1'b0}}) begin
            head_d = head_q;
        end else if (push_s && (level_after_pop_s == {LW{1'b0}})) begin
            // The entry written on this edge becomes the front.
            head_d = din;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // Pointer, head and valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {LW{1'b0}};
            rd_ptr_q <= {LW{1'b0}};
            head_q   <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign head  = head_q;
    assign full  = full_s;
    assign empty = ~valid_q;
    assign level = level_s;

endmodule

// File: rtl/cs_result_buffer.sv
// ---------------------------------------------------------------------------
// cs_result_buffer
// Discards the first WARMUP_P valid CS results after reset (window fill),
// then queues every further result tagged with an 8-bit sequence index.
// Results that find the queue full are dropped; the index still advances so
// the gap in dout_idx shows the loss, and overflow/drop_cnt record it.
//   clk   : clock
//   reset : synchronous active-high reset (flushes queue, clears statistics)
//   bus   : cs_result_buffer_if.slave (y stream in, dout stream out, stats)
// ---------------------------------------------------------------------------
module cs_result_buffer
    import cs_pkg::*;
#(
    parameter int WARMUP_P = WARMUP
) (
    input  logic               clk,
    input  logic               reset,
    cs_result_buffer_if.slave  bus
);

    localparam int         ENTRY_W     = $bits(entry_t);
    localparam state_t     RESET_STATE = (WARMUP_P == 0) ? RUN : WARM;
    localparam logic [7:0] WARM_LAST   = 8'(WARMUP_P - 1);

    state_t             state_q, state_d;
    logic [7:0]         warm_cnt_q, warm_cnt_d;
    logic [IDX_W-1:0]   seq_q, seq_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               push_req_s;
    logic               push_acc_s;
    logic               pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [ENTRY_W-1:0] head_vec_s;
    entry_t             head_s;
    entry_t             push_entry_s;
    logic [$clog2(DEPTH):0] level_s;

    assign pop_s        = ~fifo_empty_s & bus.dout_ready;
    assign push_entry_s = '{idx: seq_q, data: bus.y};

    // FSM next state, warm-up counting and push/drop bookkeeping.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        push_req_s = 1'b0;

        case (state_q)
            WARM: begin
                if (bus.y_valid) begin
                    warm_cnt_d = warm_cnt_q + 8'd1;
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = RUN;
                    end else begin
                        state_d = WARM;
                    end
                end else begin
                    warm_cnt_d = warm_cnt_q;
                end
            end
            RUN: begin
                push_req_s = bus.y_valid;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // A full queue still accepts a push when the head leaves on the same edge.
        push_acc_s = push_req_s & (~fifo_full_s | pop_s);

        if (push_req_s) begin
            seq_d = seq_q + 8'd1;
            if (!push_acc_s) begin
                overflow_d = 1'b1;
                drop_cnt_d = sat_inc(drop_cnt_q);
            end else begin
                overflow_d = overflow_q;
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            seq_d = seq_q;
        end
    end

    // FSM, counters and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            warm_cnt_q <= 8'd0;
            seq_q      <= {IDX_W{1'b0}};
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    cs_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_acc_s),
        .pop   (pop_s),
        .din   (push_entry_s),
        .head  (head_vec_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level_s)
    );

    assign head_s         = entry_t'(head_vec_s);
    assign bus.dout       = head_s.data;
    assign bus.dout_idx   = head_s.idx;
    assign bus.dout_valid = ~fifo_empty_s;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.level      = level_s;

endmodule

// File: tb/tb_cs_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_cs_result_buffer
// Directed bench for cs_result_buffer: warm-up discard, streaming, overflow
// and drop statistics, full push+pop, mid-run reset, drop saturation and
// index wrap. Inputs change 1 time unit after posedge; outputs are sampled
// there too, reflecting the edge just taken.
// ---------------------------------------------------------------------------
module tb_cs_result_buffer;
    import cs_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    cs_result_buffer_if bus ();

    cs_result_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [9:0] v);
        bus.y       = v;
        bus.y_valid = 1'b1;
        cycle();
        bus.y_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.y_valid    = 1'b0;
        bus.dout_ready = 1'b0;
        reset          = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.y = 10'd0; bus.y_valid = 1'b0; bus.dout_ready = 1'b0;
        reset = 1'b1;
        cycle();
        cycle();
        n_cmp++; if (bus.dout !== 10'd0) begin n_fail++; $display("FAIL rst_dout: got %0d want 0", bus.dout); end
        n_cmp++; if (bus.dout_idx !== 8'd0) begin n_fail++; $display("FAIL rst_idx: got %0d want 0", bus.dout_idx); end
        n_cmp++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.dout_valid); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", bus.overflow); end
        n_cmp++; if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", bus.drop_cnt); end
        n_cmp++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", bus.level); end
        reset = 1'b0;
    endtask

    task automatic test_warmup();
        for (int i = 1; i <= 8; i++) begin
            push_one(10'(i));
            n_cmp++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL warm_valid[%0d]: got %b want 0", i, bus.dout_valid); end
        end
        push_one(10'd100);
        n_cmp++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", bus.dout_valid); end
        n_cmp++; if (bus.dout !== 10'd100) begin n_fail++; $display("FAIL first_dout: got %0d want 100", bus.dout); end
        n_cmp++; if (bus.dout_idx !== 8'd0) begin n_fail++; $display("FAIL first_idx: got %0d want 0", bus.dout_idx); end
        push_one(10'd101);
        n_cmp++; if (bus.level !== 4'd2) begin n_fail++; $display("FAIL warm_level: got %0d want 2", bus.level); end
        n_cmp++; if (bus.dout !== 10'd100) begin n_fail++; $display("FAIL hold_dout: got %0d want 100", bus.dout); end
        bus.dout_ready = 1'b1;
        cycle();
        n_cmp++; if (bus.dout !== 10'd101) begin n_fail++; $display("FAIL second_dout: got %0d want 101", bus.dout); end
        n_cmp++; if (bus.dout_idx !== 8'd1) begin n_fail++; $display("FAIL second_idx: got %0d want 1", bus.dout_idx); end
        cycle();
        n_cmp++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b want 0", bus.dout_valid); end
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_stream();
        // seq continues at 2 after the two results of the warm-up test
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_one(10'(200 + i));
            n_cmp++; if (bus.dout_valid !== 1'b1 || bus.dout !== 10'(200 + i) || bus.dout_idx !== 8'(2 + i))
                begin n_fail++; $display("FAIL stream[%0d]: got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d", i, bus.dout_valid, bus.dout, bus.dout_idx, 200 + i, 2 + i); end
            n_cmp++; if (bus.level !== 4'd1 || bus.overflow !== 1'b0)
                begin n_fail++; $display("FAIL stream_lvl[%0d]: got lvl=%0d ovf=%b want lvl=1 ovf=0", i, bus.level, bus.overflow); end
        end
        cycle();
        n_cmp++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL stream_end_level: got %0d want 0", bus.level); end
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) push_one(10'(i + 1));
        for (int i = 0; i < 10; i++) begin
            push_one(10'(300 + i));
            if (i == 8) begin
                n_cmp++; if (bus.drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_first_drop: got %0d want 1", bus.drop_cnt); end
            end
        end
        n_cmp++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", bus.level); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        n_cmp++; if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop: got %0d want 2", bus.drop_cnt); end
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.dout_idx !== 8'(i) || bus.dout !== 10'(300 + i))
                begin n_fail++; $display("FAIL drain[%0d]: got i=%0d d=%0d want i=%0d d=%0d", i, bus.dout_idx, bus.dout, i, 300 + i); end
            cycle();
        end
        n_cmp++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", bus.level); end
        bus.dout_ready = 1'b0;
        push_one(10'd500);
        n_cmp++; if (bus.dout_idx !== 8'd10 || bus.dout !== 10'd500)
            begin n_fail++; $display("FAIL gap_idx: got i=%0d d=%0d want i=10 d=500", bus.dout_idx, bus.dout); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 7; i++) push_one(10'(500 + i));
        n_cmp++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL fpp_fill: got %0d want 8", bus.level); end
        bus.dout_ready = 1'b1;
        push_one(10'd600);
        bus.dout_ready = 1'b0;
        n_cmp++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL fpp_level: got %0d want 8", bus.level); end
        n_cmp++; if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL fpp_drop: got %0d want 2", bus.drop_cnt); end
        n_cmp++; if (bus.dout_idx !== 8'd11 || bus.dout !== 10'd501)
            begin n_fail++; $display("FAIL fpp_head: got i=%0d d=%0d want i=11 d=501", bus.dout_idx, bus.dout); end
    endtask

    task automatic test_reset_mid();
        bus.dout_ready = 1'b1;
        cycle(); cycle(); cycle();
        bus.dout_ready = 1'b0;
        n_cmp++; if (bus.level !== 4'd5 || bus.overflow !== 1'b1)
            begin n_fail++; $display("FAIL mid_pre: got lvl=%0d ovf=%b want lvl=5 ovf=1", bus.level, bus.overflow); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_cmp++; if (bus.level !== 4'd0 || bus.dout_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0)
            begin n_fail++; $display("FAIL mid_rst: got lvl=%0d v=%b ovf=%b drop=%0d want 0/0/0/0", bus.level, bus.dout_valid, bus.overflow, bus.drop_cnt); end
        for (int i = 0; i < 8; i++) begin
            push_one(10'(700 + i));
            n_cmp++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_warm[%0d]: got %b want 0", i, bus.dout_valid); end
        end
        push_one(10'd777);
        n_cmp++; if (bus.dout_valid !== 1'b1 || bus.dout !== 10'd777 || bus.dout_idx !== 8'd0)
            begin n_fail++; $display("FAIL mid_first: got v=%b d=%0d i=%0d want v=1 d=777 i=0", bus.dout_valid, bus.dout, bus.dout_idx); end
    endtask

    task automatic test_saturate_wrap();
        for (int i = 1; i <= 7; i++) push_one(10'(10 + i));
        for (int i = 0; i < 300; i++) begin
            push_one(10'd999);
            if (i == 254) begin
                n_cmp++; if (bus.drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", bus.drop_cnt); end
            end
        end
        n_cmp++; if (bus.drop_cnt !== 8'd255 || bus.overflow !== 1'b1 || bus.level !== 4'd8)
            begin n_fail++; $display("FAIL sat_end: got drop=%0d ovf=%b lvl=%0d want 255/1/8", bus.drop_cnt, bus.overflow, bus.level); end
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.dout_idx !== 8'(i)) begin n_fail++; $display("FAIL sat_drain[%0d]: got %0d want %0d", i, bus.dout_idx, i); end
            cycle();
        end
        // 8 stored + 300 dropped leaves seq at 308 mod 256 = 52
        for (int i = 0; i < 210; i++) begin
            push_one(10'(i));
            n_cmp++; if (bus.dout_idx !== 8'(52 + i) || bus.dout !== 10'(i))
                begin n_fail++; $display("FAIL wrap[%0d]: got i=%0d d=%0d want i=%0d d=%0d", i, bus.dout_idx, bus.dout, (52 + i) % 256, i); end
        end
        bus.dout_ready = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_warmup();
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_saturate_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
